// File: rtl/opicorv32_pcpi_pkg.sv
// opicorv32_pcpi_pkg: shared types and constants for the PCPI hub.
// Hub state encoding, RV32M opcode fields and default timeout.
package opicorv32_pcpi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    RESP_TO
  } state_t;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam int TIMEOUT_CYCLES_DEF    = 16;

endpackage

// File: rtl/opicorv32_pcpi_timer.sv
// opicorv32_pcpi_timer: clearable saturating cycle counter.
// expire is high while the count sits at LIMIT-1.
module opicorv32_pcpi_timer #(
  parameter int LIMIT = 16,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/opicorv32_pcpi_hub.sv
// opicorv32_pcpi_hub: fans one PCPI request out to two co-processors.
// Define OPICORV32_PCPI_HUB_ERR_EN to add the sticky pcpi_err output.
module opicorv32_pcpi_hub
  import opicorv32_pcpi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        pcpi_timeout,
  output logic        cp0_valid,
  output logic [31:0] cp0_insn,
  output logic [31:0] cp0_rs1,
  output logic [31:0] cp0_rs2,
  output logic        cp1_valid,
  output logic [31:0] cp1_insn,
  output logic [31:0] cp1_rs1,
  output logic [31:0] cp1_rs2,
  input  logic        cp0_wr,
  input  logic [31:0] cp0_rd,
  input  logic        cp0_wait,
  input  logic        cp0_ready,
  input  logic        cp1_wr,
  input  logic [31:0] cp1_rd,
  input  logic        cp1_wait,
  input  logic        cp1_ready
`ifdef OPICORV32_PCPI_HUB_ERR_EN
  ,
  output logic        pcpi_err
`endif
);

  state_t      state_q;
  state_t      state_d;
  logic        capture;
  logic        busy;
  logic        wait_q;
  logic        wr_q;
  logic [31:0] rd_q;
  logic [31:0] insn_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic        expire;

  assign busy = (state_q == BUSY);

  opicorv32_pcpi_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (capture | (busy & wait_q)),
    .enable (busy & ~wait_q),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pcpi_valid) begin
          state_d = BUSY;
          capture = 1'b1;
        end
      end
      BUSY: begin
        // ready beats both abort and timeout
        if (cp0_ready || cp1_ready) begin
          state_d = RESP;
        end else if (!pcpi_valid) begin
          state_d = IDLE;
        end else if (!wait_q && expire) begin
          state_d = RESP_TO;
        end
      end
      RESP:    state_d = IDLE;
      RESP_TO: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      wait_q  <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= busy & (cp0_wait | cp1_wait);
      if (capture) begin
        insn_q <= pcpi_insn;
        rs1_q  <= pcpi_rs1;
        rs2_q  <= pcpi_rs2;
      end
      if (busy && cp0_ready) begin
        rd_q <= cp0_rd;
        wr_q <= cp0_wr;
      end else if (busy && cp1_ready) begin
        rd_q <= cp1_rd;
        wr_q <= cp1_wr;
      end
    end
  end

`ifdef OPICORV32_PCPI_HUB_ERR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcpi_err <= 1'b0;
    end else if ((busy && cp0_ready && cp1_ready) ||
                 (cp0_wait && cp1_wait) ||
                 ((state_q == IDLE) && (cp0_ready || cp1_ready))) begin
      pcpi_err <= 1'b1;
    end
  end
`endif

  assign pcpi_ready   = (state_q == RESP);
  assign pcpi_timeout = (state_q == RESP_TO);
  assign pcpi_wr      = wr_q & pcpi_ready;
  assign pcpi_rd      = rd_q;
  assign pcpi_wait    = wait_q & busy;

  assign cp0_valid = busy;
  assign cp1_valid = busy;
  assign cp0_insn  = insn_q;
  assign cp1_insn  = insn_q;
  assign cp0_rs1   = rs1_q;
  assign cp1_rs1   = rs1_q;
  assign cp0_rs2   = rs2_q;
  assign cp1_rs2   = rs2_q;

endmodule

// File: tb/tb_opicorv32_pcpi_hub.sv
// tb_opicorv32_pcpi_hub: scoreboard bench for the PCPI hub.
// Co-processors are modelled cycle by cycle inside each test task.
module tb_opicorv32_pcpi_hub;
  import opicorv32_pcpi_pkg::*;

  logic        clk;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        pcpi_timeout;
  logic        cp0_valid, cp1_valid;
  logic [31:0] cp0_insn, cp0_rs1, cp0_rs2;
  logic [31:0] cp1_insn, cp1_rs1, cp1_rs2;
  logic        cp0_wr, cp0_wait, cp0_ready;
  logic        cp1_wr, cp1_wait, cp1_ready;
  logic [31:0] cp0_rd, cp1_rd;
`ifdef OPICORV32_PCPI_HUB_ERR_EN
  logic        pcpi_err;
`endif

  typedef struct {
    logic        to;
    logic [31:0] rd;
    logic        wr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  opicorv32_pcpi_hub dut (
    .clk          (clk),
    .resetn       (resetn),
    .pcpi_valid   (pcpi_valid),
    .pcpi_insn    (pcpi_insn),
    .pcpi_rs1     (pcpi_rs1),
    .pcpi_rs2     (pcpi_rs2),
    .pcpi_wr      (pcpi_wr),
    .pcpi_rd      (pcpi_rd),
    .pcpi_wait    (pcpi_wait),
    .pcpi_ready   (pcpi_ready),
    .pcpi_timeout (pcpi_timeout),
    .cp0_valid    (cp0_valid),
    .cp0_insn     (cp0_insn),
    .cp0_rs1      (cp0_rs1),
    .cp0_rs2      (cp0_rs2),
    .cp1_valid    (cp1_valid),
    .cp1_insn     (cp1_insn),
    .cp1_rs1      (cp1_rs1),
    .cp1_rs2      (cp1_rs2),
    .cp0_wr       (cp0_wr),
    .cp0_rd       (cp0_rd),
    .cp0_wait     (cp0_wait),
    .cp0_ready    (cp0_ready),
    .cp1_wr       (cp1_wr),
    .cp1_rd       (cp1_rd),
    .cp1_wait     (cp1_wait),
    .cp1_ready    (cp1_ready)
`ifdef OPICORV32_PCPI_HUB_ERR_EN
    ,
    .pcpi_err     (pcpi_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Response scoreboard: every ready/timeout pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (resetn && (pcpi_ready || pcpi_timeout)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp ready=%0b timeout=%0b rd=%h",
                 pcpi_ready, pcpi_timeout, pcpi_rd);
      end else begin
        e = sb.pop_front();
        if ({pcpi_timeout, pcpi_ready, pcpi_wr} !== {e.to, ~e.to, e.wr} ||
            (!e.to && pcpi_rd !== e.rd)) begin
          errors++;
          $display("FAIL resp got to=%0b rdy=%0b wr=%0b rd=%h want to=%0b wr=%0b rd=%h",
                   pcpi_timeout, pcpi_ready, pcpi_wr, pcpi_rd, e.to, e.wr, e.rd);
        end
      end
    end
  end

  task automatic cp_idle();
    cp0_wr = 0; cp0_rd = 0; cp0_wait = 0; cp0_ready = 0;
    cp1_wr = 0; cp1_rd = 0; cp1_wait = 0; cp1_ready = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    pcpi_valid = 0;
    pcpi_insn = 0;
    pcpi_rs1 = 0;
    pcpi_rs2 = 0;
    cp_idle();
    repeat (2) @(negedge clk);
    checks++;
    if ({pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
         cp0_valid, cp1_valid, cp0_insn, cp0_rs1, cp0_rs2,
         cp1_insn, cp1_rs1, cp1_rs2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rd=%h valid=%0b%0b want all zero",
               pcpi_rd, cp0_valid, cp1_valid);
    end
`ifdef OPICORV32_PCPI_HUB_ERR_EN
    checks++;
    if (pcpi_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %0b want 0", pcpi_err);
    end
`endif
    resetn = 1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] insn;
    insn = {FUNCT7_MULDIV, 5'd2, 5'd1, 3'b000, 5'd3, OPCODE_OP};
    pcpi_valid = 1; pcpi_insn = insn; pcpi_rs1 = 7; pcpi_rs2 = 6;
    sb.push_back('{to: 1'b0, rd: 32'h2A, wr: 1'b1});
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({cp0_valid, cp1_valid, cp0_insn, cp1_insn, cp0_rs1, cp1_rs1, cp0_rs2, cp1_rs2}
            !== {2'b11, insn, insn, 32'd7, 32'd7, 32'd6, 32'd6}) begin
          errors++;
          $display("FAIL mul_fanout valid=%0b%0b insn=%h rs1=%h rs2=%h want 11 %h 7 6",
                   cp0_valid, cp1_valid, cp0_insn, cp0_rs1, cp0_rs2, insn);
        end
      end
      if (c == 2 || c == 4) begin
        checks++;
        if (pcpi_wait !== (c == 4)) begin
          errors++;
          $display("FAIL mul_wait c=%0d got %0b want %0b", c, pcpi_wait, c == 4);
        end
      end
      if (c == 3) cp0_wait = 1;
      if (c == 10) begin cp0_ready = 1; cp0_rd = 42; cp0_wr = 1; end
      if (c == 11) begin
        checks++;
        if ({pcpi_ready, cp0_valid, cp1_valid} !== 3'b100) begin
          errors++;
          $display("FAIL mul_ready_c11 ready=%0b valid=%0b%0b want 1 00",
                   pcpi_ready, cp0_valid, cp1_valid);
        end
        cp_idle();
        pcpi_valid = 0;
      end
      if (c == 12) begin
        checks++;
        if (pcpi_ready !== 1'b0 || pcpi_rd !== 32'h2A) begin
          errors++;
          $display("FAIL mul_hold ready=%0b rd=%h want 0 0000002a", pcpi_ready, pcpi_rd);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int seen;
    seen = -1;
    pcpi_valid = 1; pcpi_insn = 32'h0000000B; pcpi_rs1 = 1; pcpi_rs2 = 2;
    sb.push_back('{to: 1'b1, rd: 32'h0, wr: 1'b0});
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (pcpi_timeout && seen < 0) seen = c;
      if (c == 17) pcpi_valid = 0;
      if (c == 18) begin
        checks++;
        if ({cp0_valid, pcpi_timeout, pcpi_ready} !== 3'b000) begin
          errors++;
          $display("FAIL timeout_idle valid=%0b to=%0b rdy=%0b want 000",
                   cp0_valid, pcpi_timeout, pcpi_ready);
        end
      end
    end
    checks++;
    if (seen != 17) begin
      errors++;
      $display("FAIL timeout_cycle got %0d want 17", seen);
    end
  endtask

  task automatic test_long_wait();
    int to_seen;
    to_seen = 0;
    pcpi_valid = 1;
    pcpi_insn = {FUNCT7_MULDIV, 5'd2, 5'd1, 3'b100, 5'd3, OPCODE_OP};
    pcpi_rs1 = 100; pcpi_rs2 = 3;
    sb.push_back('{to: 1'b0, rd: 32'hDEADBEEF, wr: 1'b1});
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      if (pcpi_timeout) to_seen++;
      if (c == 2) cp1_wait = 1;
      if (c == 42) begin cp1_wait = 0; cp1_ready = 1; cp1_rd = 32'hDEADBEEF; cp1_wr = 1; end
      if (c == 43) begin
        checks++;
        if (pcpi_ready !== 1'b1 || pcpi_rd !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL long_ready rdy=%0b rd=%h want 1 deadbeef", pcpi_ready, pcpi_rd);
        end
        cp_idle();
        pcpi_valid = 0;
      end
    end
    checks++;
    if (to_seen != 0) begin
      errors++;
      $display("FAIL long_no_timeout got %0d pulses want 0", to_seen);
    end
  endtask

  task automatic test_ready_vs_timeout();
    pcpi_valid = 1; pcpi_insn = 32'h0200_0033; pcpi_rs1 = 5; pcpi_rs2 = 5;
    sb.push_back('{to: 1'b0, rd: 32'h55, wr: 1'b0});
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 16) begin cp1_ready = 1; cp1_rd = 32'h55; cp1_wr = 0; end
      if (c == 17) begin
        checks++;
        if ({pcpi_ready, pcpi_timeout} !== 2'b10) begin
          errors++;
          $display("FAIL race_c17 rdy=%0b to=%0b want 1 0", pcpi_ready, pcpi_timeout);
        end
        cp_idle();
        pcpi_valid = 0;
      end
      if (c == 18) begin
        checks++;
        if (pcpi_timeout !== 1'b0) begin
          errors++;
          $display("FAIL race_c18 to=%0b want 0", pcpi_timeout);
        end
      end
    end
  endtask

  task automatic test_collision();
    pcpi_valid = 1; pcpi_insn = 32'h0200_0033; pcpi_rs1 = 3; pcpi_rs2 = 4;
    sb.push_back('{to: 1'b0, rd: 32'h11, wr: 1'b1});
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
`ifdef OPICORV32_PCPI_HUB_ERR_EN
      if (c == 2 || c == 4 || c == 6) begin
        checks++;
        if (pcpi_err !== (c != 2)) begin
          errors++;
          $display("FAIL coll_err c=%0d got %0b want %0b", c, pcpi_err, c != 2);
        end
      end
`endif
      if (c == 3) begin
        cp0_ready = 1; cp0_rd = 32'h11; cp0_wr = 1;
        cp1_ready = 1; cp1_rd = 32'h22; cp1_wr = 1;
      end
      if (c == 4) begin
        checks++;
        if (pcpi_ready !== 1'b1 || pcpi_rd !== 32'h11) begin
          errors++;
          $display("FAIL coll_rd rdy=%0b rd=%h want 1 00000011", pcpi_ready, pcpi_rd);
        end
        cp_idle();
        pcpi_valid = 0;
      end
    end
  endtask

  task automatic test_abort();
    int resp;
    resp = 0;
    pcpi_valid = 1; pcpi_insn = 32'h0200_0033; pcpi_rs1 = 9; pcpi_rs2 = 9;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (pcpi_ready || pcpi_timeout) resp++;
      if (c == 4) begin
        checks++;
        if (cp0_valid !== 1'b1) begin
          errors++;
          $display("FAIL abort_c4 valid=%0b want 1", cp0_valid);
        end
        pcpi_valid = 0;
      end
      if (c == 5) begin
        checks++;
        if ({cp0_valid, cp1_valid} !== 2'b00) begin
          errors++;
          $display("FAIL abort_c5 valid=%0b%0b want 00", cp0_valid, cp1_valid);
        end
      end
    end
    checks++;
    if (resp != 0) begin
      errors++;
      $display("FAIL abort_no_resp got %0d pulses want 0", resp);
    end
  endtask

  task automatic test_reset_mid();
    pcpi_valid = 1; pcpi_insn = 32'h0200_0033; pcpi_rs1 = 32'hA5A5; pcpi_rs2 = 1;
    repeat (2) @(negedge clk);
    cp0_wait = 1;
    @(negedge clk);
    checks++;
    if (cp0_valid !== 1'b1 || pcpi_rd === 32'h0) begin
      errors++;
      $display("FAIL rstmid_pre valid=%0b rd=%h want 1 nonzero", cp0_valid, pcpi_rd);
    end
    #2 resetn = 0;
    #1;
    checks++;
    if ({pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
         cp0_valid, cp1_valid, cp0_insn, cp0_rs1, cp1_rs2} !== '0) begin
      errors++;
      $display("FAIL rstmid_async rd=%h valid=%0b wait=%0b rs1=%h want all zero",
               pcpi_rd, cp0_valid, pcpi_wait, cp0_rs1);
    end
    @(negedge clk);
    resetn = 1;
    pcpi_valid = 0;
    cp_idle();
    @(negedge clk);
    cp0_ready = 1; cp0_rd = 32'h99; cp0_wr = 1;
    @(negedge clk);
    cp_idle();
    @(negedge clk);
    checks++;
    if ({pcpi_ready, pcpi_wr, pcpi_rd, cp0_valid} !== '0) begin
      errors++;
      $display("FAIL rstmid_ignore rdy=%0b rd=%h valid=%0b want 0 0 0",
               pcpi_ready, pcpi_rd, cp0_valid);
    end
`ifdef OPICORV32_PCPI_HUB_ERR_EN
    checks++;
    if (pcpi_err !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_err got %0b want 1", pcpi_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mul();
    test_timeout();
    test_long_wait();
    test_ready_vs_timeout();
    test_collision();
    test_abort();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
